// File: rtl/ibex_cx_unit.sv
// ibex_cx_unit: execute-stage unit for composable custom-extension (CX) instructions.
// Checks CX CSR permissions, issues a valid/ready request to the selected accelerator and returns its result.
module ibex_cx_unit #(
  parameter int unsigned CX_ID_WIDTH = 8,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cx_valid_i,
  output logic                   cx_ready_o,
  input  logic [6:0]             cx_opcode_i,
  input  logic [9:0]             cx_funct_i,
  input  logic [31:0]            cx_op_a_i,
  input  logic [31:0]            cx_op_b_i,
  output logic [31:0]            cx_result_o,
  output logic                   cx_result_valid_o,
  output logic                   cx_illegal_o,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [31:0]            csr_wdata_i,
  output logic [31:0]            csr_rdata_o,
  output logic                   cx_req_valid_o,
  input  logic                   cx_req_ready_i,
  output logic [CX_ID_WIDTH-1:0] cx_req_id_o,
  output logic [16:0]            cx_req_func_o,
  output logic [31:0]            cx_req_a_o,
  output logic [31:0]            cx_req_b_o,
  input  logic                   cx_resp_valid_i,
  input  logic [31:0]            cx_resp_data_i,
  input  logic                   cx_resp_err_i,
  output logic                   cx_resp_ready_o
);

  localparam logic [6:0]  OPCODE_CX_REG  = 7'h0b;
  localparam logic [6:0]  OPCODE_CX_IMM  = 7'h2b;
  localparam logic [6:0]  OPCODE_CX_FLEX = 7'h5b;
  localparam logic [11:0] CSR_CX_IDX     = 12'h800;
  localparam logic [11:0] CSR_CX_STAT    = 12'h801;
  localparam logic [11:0] CSR_MCX_IDX    = 12'hBC0;
  localparam logic [11:0] CSR_MCX_EN     = 12'hBC1;
  localparam int unsigned CNT_W          = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_r;
  logic [31:0]            cx_idx_r;
  logic [31:0]            mcx_en_r;
  logic [CX_ID_WIDTH-1:0] mcx_idx_r;
  logic [3:1]             stat_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   ready_r;
  logic                   req_valid_r;
  logic                   resp_ready_r;
  logic                   result_valid_r;
  logic                   illegal_r;
  logic [CX_ID_WIDTH-1:0] req_id_r;
  logic [16:0]            req_func_r;
  logic [31:0]            req_a_r;
  logic [31:0]            req_b_r;
  logic [31:0]            result_r;

  logic                   opcode_ok_s;
  logic                   legal_s;
  logic                   accept_s;
  logic                   resp_take_s;
  logic                   timeout_s;
  logic [3:1]             stat_set_s;
  logic [3:1]             stat_clr_s;

  // opcode decode: only the three CX major opcodes are candidates for a legal issue
  always_comb begin
    case (cx_opcode_i)
      OPCODE_CX_REG, OPCODE_CX_IMM, OPCODE_CX_FLEX: opcode_ok_s = 1'b1;
      default:                                      opcode_ok_s = 1'b0;
    endcase
  end

  assign legal_s     = opcode_ok_s && (cx_idx_r[31:5] == 27'd0) && mcx_en_r[cx_idx_r[4:0]];
  assign accept_s    = cx_valid_i && ready_r && (state_r == IDLE);
  assign resp_take_s = (state_r == RESP) && cx_resp_valid_i;
  assign timeout_s   = (state_r == RESP) && !cx_resp_valid_i && (cnt_r == CNT_LAST);
  assign stat_set_s  = {timeout_s, accept_s && !legal_s, resp_take_s && cx_resp_err_i};
  assign stat_clr_s  = (csr_we_i && (csr_addr_i == CSR_CX_STAT)) ? csr_wdata_i[3:1] : 3'b000;

  // CSR storage; a hardware status set overrides a write-1-clear in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cx_idx_r  <= 32'd0;
      mcx_en_r  <= 32'd0;
      mcx_idx_r <= '0;
      stat_r    <= 3'b000;
    end else begin
      if (csr_we_i) begin
        case (csr_addr_i)
          CSR_CX_IDX:  cx_idx_r  <= csr_wdata_i;
          CSR_MCX_IDX: mcx_idx_r <= csr_wdata_i[CX_ID_WIDTH-1:0];
          CSR_MCX_EN:  mcx_en_r  <= csr_wdata_i;
          default:     cx_idx_r  <= cx_idx_r;
        endcase
      end
      stat_r <= (stat_r & ~stat_clr_s) | stat_set_s;
    end
  end

  // CSR read mux
  always_comb begin
    case (csr_addr_i)
      CSR_CX_IDX:  csr_rdata_o = cx_idx_r;
      CSR_CX_STAT: csr_rdata_o = {28'd0, stat_r, state_r != IDLE};
      CSR_MCX_IDX: csr_rdata_o = 32'(mcx_idx_r);
      CSR_MCX_EN:  csr_rdata_o = mcx_en_r;
      default:     csr_rdata_o = 32'd0;
    endcase
  end

  // issue FSM with registered handshake and writeback outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      ready_r        <= 1'b1;
      req_valid_r    <= 1'b0;
      resp_ready_r   <= 1'b0;
      result_valid_r <= 1'b0;
      illegal_r      <= 1'b0;
      cnt_r          <= '0;
      req_id_r       <= '0;
      req_func_r     <= 17'd0;
      req_a_r        <= 32'd0;
      req_b_r        <= 32'd0;
      result_r       <= 32'd0;
    end else begin
      result_valid_r <= 1'b0;
      illegal_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && legal_s) begin
            state_r     <= REQ;
            ready_r     <= 1'b0;
            req_valid_r <= 1'b1;
            req_id_r    <= cx_idx_r[CX_ID_WIDTH-1:0] + mcx_idx_r;
            req_func_r  <= {cx_opcode_i, cx_funct_i};
            req_a_r     <= cx_op_a_i;
            req_b_r     <= cx_op_b_i;
          end else begin
            illegal_r <= accept_s;
            ready_r   <= 1'b1;
          end
        end
        REQ: begin
          if (cx_req_ready_i) begin
            state_r      <= RESP;
            req_valid_r  <= 1'b0;
            resp_ready_r <= 1'b1;
            cnt_r        <= '0;
          end else begin
            req_valid_r <= 1'b1;
          end
        end
        RESP: begin
          // a response coinciding with the last timeout cycle still wins
          if (cx_resp_valid_i) begin
            state_r        <= IDLE;
            resp_ready_r   <= 1'b0;
            result_valid_r <= 1'b1;
            result_r       <= cx_resp_err_i ? 32'd0 : cx_resp_data_i;
          end else if (cnt_r == CNT_LAST) begin
            state_r        <= IDLE;
            resp_ready_r   <= 1'b0;
            result_valid_r <= 1'b1;
            result_r       <= 32'd0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r      <= IDLE;
          ready_r      <= 1'b1;
          req_valid_r  <= 1'b0;
          resp_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign cx_ready_o        = ready_r;
  assign cx_req_valid_o    = req_valid_r;
  assign cx_resp_ready_o   = resp_ready_r;
  assign cx_result_valid_o = result_valid_r;
  assign cx_illegal_o      = illegal_r;
  assign cx_result_o       = result_r;
  assign cx_req_id_o       = req_id_r;
  assign cx_req_func_o     = req_func_r;
  assign cx_req_a_o        = req_a_r;
  assign cx_req_b_o        = req_b_r;

endmodule

// File: tb/tb_ibex_cx_unit.sv
// Self-checking bench for ibex_cx_unit: directed vector table, randomized ops against a
// cycle-count reference model, and hand-written reset-abort sequence.
module tb_ibex_cx_unit;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cx_valid = 1'b0;
  logic        cx_ready;
  logic [6:0]  cx_opcode = 7'd0;
  logic [9:0]  cx_funct = 10'd0;
  logic [31:0] cx_op_a = 32'd0;
  logic [31:0] cx_op_b = 32'd0;
  logic [31:0] cx_result;
  logic        cx_result_valid;
  logic        cx_illegal;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic [31:0] csr_rdata;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [7:0]  req_id;
  logic [16:0] req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic        resp_err = 1'b0;
  logic        resp_ready;

  ibex_cx_unit #(.CX_ID_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cx_valid_i(cx_valid), .cx_ready_o(cx_ready), .cx_opcode_i(cx_opcode), .cx_funct_i(cx_funct),
    .cx_op_a_i(cx_op_a), .cx_op_b_i(cx_op_b), .cx_result_o(cx_result),
    .cx_result_valid_o(cx_result_valid), .cx_illegal_o(cx_illegal),
    .csr_we_i(csr_we), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
    .cx_req_valid_o(req_valid), .cx_req_ready_i(req_ready), .cx_req_id_o(req_id),
    .cx_req_func_o(req_func), .cx_req_a_o(req_a), .cx_req_b_o(req_b),
    .cx_resp_valid_i(resp_valid), .cx_resp_data_i(resp_data), .cx_resp_err_i(resp_err),
    .cx_resp_ready_o(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [9:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] idx;
    logic [31:0] en;
    logic [7:0]  mcx;
    int          rd;   // cycles req_ready is held low
    int          rsd;  // RESP cycle index carrying the response, -1 = none
    logic        err;
    logic [31:0] data;
    logic [31:0] w1c;  // STAT write issued alongside the response
    logic        ill;
    logic [31:0] res;
    logic [7:0]  id;
    int          lat;
    logic [31:0] stat;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  string       cur_tag = "";
  int          o_lat;
  logic        o_ill, o_res_seen, o_req_seen, o_stable, o_ready_res, o_ready_after;
  logic [31:0] o_res, o_a, o_b;
  logic [7:0]  o_id;
  logic [16:0] o_func;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s actual=%0h expected=%0h", cur_tag, nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    step();
    csr_we = 1'b0; csr_wdata = 32'd0;
  endtask

  task automatic chk_csr(input string nm, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  // Issue one instruction and act as the accelerator; records what the DUT did.
  task automatic run_op(input vec_t v);
    int cyc, req_cnt, k;
    logic done;
    o_lat = -1; o_ill = 1'b0; o_res_seen = 1'b0; o_res = 32'd0; o_req_seen = 1'b0;
    o_stable = 1'b1; o_ready_res = 1'b1; o_ready_after = 1'b0;
    o_id = 8'd0; o_func = 17'd0; o_a = 32'd0; o_b = 32'd0;
    for (int w = 0; w < 5 && !cx_ready; w++) step();
    cx_valid = 1'b1; cx_opcode = v.opc; cx_funct = v.fn; cx_op_a = v.a; cx_op_b = v.b;
    step();
    cx_valid = 1'b0;
    cyc = 1; req_cnt = 0; k = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_data = 32'd0;
      csr_we = 1'b0; csr_wdata = 32'd0; csr_addr = 12'h801;
      #1;
      if (cx_illegal) begin
        o_ill = 1'b1; o_lat = cyc; done = 1'b1;
      end else if (cx_result_valid) begin
        o_res_seen = 1'b1; o_res = cx_result; o_lat = cyc; o_ready_res = cx_ready; done = 1'b1;
      end else begin
        if (cx_ready || !csr_rdata[0]) o_stable = 1'b0;
        if (req_valid) begin
          if (!o_req_seen) begin
            o_id = req_id; o_func = req_func; o_a = req_a; o_b = req_b;
          end else if (req_id !== o_id || req_func !== o_func || req_a !== o_a || req_b !== o_b) begin
            o_stable = 1'b0;
          end
          o_req_seen = 1'b1;
          if (req_cnt >= v.rd) req_ready = 1'b1;
          req_cnt++;
        end
        if (resp_ready) begin
          if (k == v.rsd) begin
            resp_valid = 1'b1; resp_data = v.data; resp_err = v.err;
            if (v.w1c != 32'd0) begin
              csr_we = 1'b1; csr_wdata = v.w1c;
            end
          end
          k++;
        end
        step();
        cyc++;
      end
    end
    req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; csr_we = 1'b0;
    if (done) begin
      step();
      o_ready_after = cx_ready;
    end
  endtask

  task automatic do_vec(input vec_t v);
    csr_write(12'h800, v.idx);
    csr_write(12'hBC1, v.en);
    csr_write(12'hBC0, 32'(v.mcx));
    run_op(v);
    chk("illegal", 32'(o_ill), 32'(v.ill));
    chk("req_seen", 32'(o_req_seen), 32'(!v.ill));
    chk("latency", o_lat, v.lat);
    chk("ready_after", 32'(o_ready_after), 32'd1);
    if (v.ill) begin
      chk("result_hold", cx_result, v.res);
    end else begin
      chk("result_strobe", 32'(o_res_seen), 32'd1);
      chk("result", o_res, v.res);
      chk("req_id", 32'(o_id), 32'(v.id));
      chk("req_func", 32'(o_func), 32'({v.opc, v.fn}));
      chk("req_a", o_a, v.a);
      chk("req_b", o_b, v.b);
      chk("busy_stable", 32'(o_stable), 32'd1);
      chk("ready_at_result", 32'(o_ready_res), 32'd0);
    end
    chk_csr("stat", 12'h801, v.stat);
  endtask

  // Reference behaviour from the instruction-level rules: legality, id sum, latency, status
  function automatic vec_t model(input vec_t v, input logic [31:0] held, input logic [31:0] stat_in);
    vec_t r;
    logic legal;
    r = v;
    r.stat = stat_in;
    legal = (v.opc == 7'h0b || v.opc == 7'h2b || v.opc == 7'h5b) && (v.idx < 32) && v.en[v.idx[4:0]];
    r.id = 8'((v.idx + 32'(v.mcx)) % 256);
    if (!legal) begin
      r.ill = 1'b1; r.res = held; r.lat = 1; r.stat = r.stat | 32'h4;
    end else if (v.rsd >= 0 && v.rsd < TIMEOUT) begin
      r.ill = 1'b0; r.lat = 3 + v.rd + v.rsd; r.res = v.err ? 32'd0 : v.data;
      if (v.err) r.stat = r.stat | 32'h2;
    end else begin
      r.ill = 1'b0; r.lat = 2 + v.rd + TIMEOUT; r.res = 32'd0; r.stat = r.stat | 32'h8;
    end
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    vec_t v;
    logic [31:0] held, stat_m;
    logic [11:0] addrs [4];

    tbl[0]  = '{7'h0b, 10'h005, 32'd3, 32'd4, 32'd0, 32'h1, 8'h10, 0, 0, 1'b0, 32'd7, 32'd0,
                1'b0, 32'd7, 8'h10, 3, 32'h0};
    tbl[1]  = '{7'h2b, 10'h001, 32'd1, 32'd2, 32'd0, 32'h0, 8'h10, 0, 0, 1'b0, 32'd0, 32'd0,
                1'b1, 32'd7, 8'h00, 1, 32'h4};
    tbl[2]  = '{7'h5b, 10'h3ff, 32'hAAAA5555, 32'h12345678, 32'd3, 32'h8, 8'h20, 5, 1, 1'b0, 32'hCAFEF00D, 32'd0,
                1'b0, 32'hCAFEF00D, 8'h23, 9, 32'h0};
    tbl[3]  = '{7'h0b, 10'h010, 32'd5, 32'd6, 32'd0, 32'h1, 8'h00, 0, -1, 1'b0, 32'd0, 32'd0,
                1'b0, 32'd0, 8'h00, 10, 32'h8};
    tbl[4]  = '{7'h0b, 10'h011, 32'd5, 32'd6, 32'd0, 32'h1, 8'h00, 0, 7, 1'b0, 32'h1234, 32'd0,
                1'b0, 32'h1234, 8'h00, 10, 32'h0};
    tbl[5]  = '{7'h2b, 10'h020, 32'd1, 32'd1, 32'd0, 32'h1, 8'h00, 0, 0, 1'b1, 32'hDEAD, 32'h2,
                1'b0, 32'd0, 8'h00, 3, 32'h2};
    tbl[6]  = '{7'h33, 10'h000, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 8'h00, 0, 0, 1'b0, 32'h99, 32'd0,
                1'b1, 32'd0, 8'h00, 1, 32'h4};
    tbl[7]  = '{7'h0b, 10'h001, 32'd1, 32'd1, 32'd32, 32'hFFFFFFFF, 8'h00, 0, 0, 1'b0, 32'h99, 32'd0,
                1'b1, 32'd0, 8'h00, 1, 32'h4};
    tbl[8]  = '{7'h2b, 10'h155, 32'h1, 32'h2, 32'd31, 32'h80000000, 8'hF0, 2, 3, 1'b0, 32'h55, 32'd0,
                1'b0, 32'h55, 8'h0F, 8, 32'h0};
    tbl[9]  = '{7'h5b, 10'h001, 32'd1, 32'd1, 32'h105, 32'hFFFFFFFF, 8'h00, 0, 0, 1'b0, 32'h0, 32'd0,
                1'b1, 32'h55, 8'h00, 1, 32'h4};
    tbl[10] = '{7'h5b, 10'h2aa, 32'h7, 32'h9, 32'd1, 32'h2, 8'h01, 12, 2, 1'b0, 32'h77, 32'd0,
                1'b0, 32'h77, 8'h02, 17, 32'h0};
    addrs[0] = 12'h800; addrs[1] = 12'h801; addrs[2] = 12'hBC0; addrs[3] = 12'hBC1;

    // reset state
    cur_tag = "reset";
    step(); step();
    rst = 1'b0;
    #1;
    chk("flags", 32'({cx_ready, req_valid, resp_ready, cx_result_valid, cx_illegal}), 32'h10);
    chk("result", cx_result, 32'd0);
    for (int i = 0; i < 4; i++) chk_csr($sformatf("csr%0d", i), addrs[i], 32'd0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_vec(tbl[i]);
      csr_write(12'h801, 32'hE);
      chk_csr("stat_clear", 12'h801, 32'd0);
    end

    // randomized ops against the reference model, status accumulates between clears
    held = 32'h77;
    stat_m = 32'd0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       v.opc = 7'h0b;
        1:       v.opc = 7'h2b;
        2:       v.opc = 7'h5b;
        default: v.opc = 7'($urandom);
      endcase
      v.fn = 10'($urandom); v.a = $urandom; v.b = $urandom;
      v.idx = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      v.en = $urandom | $urandom; v.mcx = 8'($urandom);
      v.rd = $urandom_range(0, 3); v.rsd = $urandom_range(0, 9);
      v.err = ($urandom_range(0, 3) == 0); v.data = $urandom; v.w1c = 32'd0;
      v = model(v, held, stat_m);
      cur_tag = $sformatf("rnd%0d", i);
      do_vec(v);
      stat_m = v.stat;
      if (!v.ill) held = v.res;
      if (i % 8 == 7) begin
        csr_write(12'h801, 32'hE);
        stat_m = 32'd0;
      end
    end

    // reset while waiting in RESP aborts the operation
    cur_tag = "rst_abort";
    csr_write(12'h800, 32'd0);
    csr_write(12'hBC1, 32'h1);
    csr_write(12'hBC0, 32'h10);
    cx_valid = 1'b1; cx_opcode = 7'h0b; cx_funct = 10'h1; cx_op_a = 32'd1; cx_op_b = 32'd2;
    step();
    cx_valid = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("in_resp", 32'(resp_ready), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flags", 32'({cx_ready, req_valid, resp_ready, cx_result_valid, cx_illegal}), 32'h10);
    chk("result", cx_result, 32'd0);
    for (int i = 0; i < 4; i++) chk_csr($sformatf("csr%0d", i), addrs[i], 32'd0);
    resp_valid = 1'b1; resp_data = 32'h1234;
    step();
    resp_valid = 1'b0;
    chk("late_resp_flags", 32'({cx_ready, resp_ready, cx_result_valid, cx_illegal}), 32'h8);
    step();
    chk("late_resp_result", 32'({cx_result_valid, cx_result}), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
